multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle RV32I control FSM. Sequences the shared datapath (one memory port, one ALU, IR/MDR/ALUOut/OldPC regs) through
//  FETCH/DECODE/EXECUTE/MEM/WB. Emits per-state Moore strobes; stretches memory states on a ready handshake; traps illegal
//  opcodes and memory timeouts into a sticky ERROR state. Sits between the instruction register and the datapath muxes.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting on mem_ready in one memory state; 0 disables the timeout
//  CNT_W        5   width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk            in   1  single clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  opcode         in   7  IR[6:0], valid from DECODE onward
//  mem_ready      in   1  memory completes current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (branch)
//  pc_source      out  2  00 ALU result, 01 ALUOut, 10 ALUOut & ~1
//  iord           out  1  0 address=PC, 1 address=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load IR (and OldPC<=PC)
//  mem_to_reg     out  2  00 ALUOut, 01 MDR, 10 live ALU result
//  reg_write      out  1  register file write
//  alu_src_a      out  2  00 PC, 01 OldPC, 10 rs1
//  alu_src_b      out  2  00 rs2, 01 const 4, 10 imm
//  alu_op         out  2  00 add, 01 sub/compare, 10 R funct, 11 I funct
//  fault          out  2  00 none, 01 illegal opcode, 10 mem timeout; sticky
//  state          out  4  current state, debug
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, fault=00, wait counter=0; IDLE drives every output 0. IDLE->FETCH next cycle.
//  - Outputs are pure functions of state (+mem_ready where noted); unlisted outputs are 0 in each state.
//  - FETCH(1): iord=0, mem_read=1, src_a=00, src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
//    Stays in FETCH until mem_ready; then ->DECODE.
//  - DECODE(2): src_a=01, src_b=10, alu_op=00 (ALUOut<=OldPC+imm). Next by opcode: 0000011/0100011->MEMADR,
//    0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, 1100111->JALR; other->ERROR, fault=01.
//  - MEMADR(3): src_a=10, src_b=10, alu_op=00; ->MEMRD if opcode=0000011 else MEMWR.
//  - MEMRD(4): iord=1, mem_read=1; wait for mem_ready, then ->MEMWB.  MEMWB(5): reg_write=1, mem_to_reg=01; ->FETCH.
//  - MEMWR(6): iord=1, mem_write=1; wait for mem_ready, then ->FETCH.
//  - EXEC_R(7): src_a=10, src_b=00, alu_op=10; ->ALUWB.  EXEC_I(8): src_a=10, src_b=10, alu_op=11; ->ALUWB.
//  - ALUWB(9): reg_write=1, mem_to_reg=00; ->FETCH.
//  - BRANCH(10): src_a=10, src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH.
//  - JAL(11): src_a=01, src_b=01, alu_op=00, reg_write=1, mem_to_reg=10, pc_write=1, pc_source=01; ->FETCH.
//  - JALR(12): src_a=10, src_b=10, alu_op=00 (ALUOut<=rs1+imm); ->JALR_LINK.
//  - JALR_LINK(13): src_a=01, src_b=01, alu_op=00, reg_write=1, mem_to_reg=10, pc_write=1, pc_source=10; ->FETCH.
//  - ERROR(15): all strobes 0; held until reset. fault keeps first cause; never overwritten.
//  - Latency with zero-wait memory: R/I 4, lw 5, sw 4, branch 3, jal 3, jalr 4 cycles.
//  - Wait counter: cleared on entry to FETCH/MEMRD/MEMWR and on mem_ready; +1 each waiting cycle. If MEM_TIMEOUT!=0 and
//    counter reaches MEM_TIMEOUT-1 with mem_ready=0 -> ERROR, fault=10. mem_ready in that same cycle wins (no fault).
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored. opcode sampled only in DECODE/MEMADR; changes elsewhere ignored.
//  - Reset asserted mid-instruction: immediate return to IDLE; no strobe may glitch high during reset.
// STRUCTURE
//  - Package riscv_ctrl_pkg: opcode constants, state encoding (4-bit), alu_op/alu_src/pc_source/mem_to_reg/fault codes.
//  - Sub-module mc_wait_timer (clear, count, expired) holds the timeout counter; FSM next-state/output logic stays here.
// TESTING
//  1. Reset release, mem_ready=1, opcode=0110011 -> IDLE,FETCH,DECODE,EXEC_R,ALUWB,FETCH; reg_write=1 only in ALUWB.
//  2. opcode=0000011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1, iord=1; MEMWB reg_write, mem_to_reg=01.
//  3. opcode=1100111 -> JALR then JALR_LINK with pc_source=10, mem_to_reg=10, pc_write=1; opcode=1101111 -> JAL single state.
//  4. opcode=1111111 in DECODE -> ERROR, fault=01, all strobes 0 for 20 cycles; rst_n pulse -> IDLE, fault=00.
//  5. MEM_TIMEOUT=16, mem_ready stuck 0 in FETCH -> ERROR after 16 cycles, fault=10; ready on cycle 16 -> DECODE, no fault.
//  6. rst_n dropped asynchronously in MEMWR -> state=IDLE and mem_write=0 before next clock edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states
// and the select/operation codes it drives into the datapath.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEMADR    = 4'd3,
        S_MEMRD     = 4'd4,
        S_MEMWB     = 4'd5,
        S_MEMWR     = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALUWB     = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR      = 4'd12,
        S_JALR_LINK = 4'd13,
        S_ERROR     = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_ALU    = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // States that own the memory port and may be stretched by mem_ready.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the last waiting
// cycle allowed before the controller gives up (never fires when MEM_TIMEOUT=0).
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: Moore strobes per state for the shared
// datapath, ready-stretched memory states and a sticky trap on faults.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] fault,
    output logic [3:0] state
);

    state_t     cur, nxt;
    logic [1:0] fault_nxt;
    logic       in_mem, timed_out;

    // The counter only runs while a memory state is stalled; anything else resets it.
    assign in_mem = is_mem_state(cur);

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_mem || mem_ready),
        .count  (in_mem && !mem_ready),
        .expired(timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= S_IDLE;
            fault <= FAULT_NONE;
        end else begin
            cur   <= nxt;
            fault <= fault_nxt;
        end
    end

    assign state = cur;

    always_comb begin
        nxt           = cur;
        fault_nxt     = fault;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = WB_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;

        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXEC_R;
                    OP_ITYPE:          nxt = S_EXEC_I;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR;
                    default: begin
                        nxt       = S_ERROR;
                        fault_nxt = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                nxt       = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_RFUNCT;
                nxt       = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_IFUNCT;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_RS1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                nxt           = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                reg_write  = 1'b1;
                mem_to_reg = WB_ALU;
                pc_write   = 1'b1;
                pc_source  = PCSRC_ALUOUT;
                nxt        = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                nxt       = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                reg_write  = 1'b1;
                mem_to_reg = WB_ALU;
                pc_write   = 1'b1;
                pc_source  = PCSRC_JALR;
                nxt        = S_FETCH;
            end
            S_ERROR: nxt = S_ERROR;
            default: nxt = S_ERROR;
        endcase

        // A completing access in the final allowed cycle still wins over the timeout.
        if (in_mem && !mem_ready && timed_out) begin
            nxt       = S_ERROR;
            fault_nxt = FAULT_TIMEOUT;
        end
    end

endmodule
